// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Sticky framing-error and overrun flags, cleared by err_clr.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [4:0] fifo_count,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] L_BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] L_HALF_END = CW'(DIV / 2 - 1);
    localparam logic [4:0]    L_DEPTH    = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic          r_rx_prev;
    logic [1:0]    r_arm;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_baud;
    logic [CW-1:0] w_baud_nx;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          r_ferr_wait;
    logic          w_ferr_wait_nx;
    logic          w_push;
    logic          w_ferr_set;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_frame_err;
    logic          r_overrun;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;

    // The previous-sample register stays 0 until the synchronizer has
    // flushed its reset value, so a line held low at release never
    // looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b0;
            r_arm     <= 2'b00;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_arm     <= {r_arm[0], 1'b1};
            r_rx_prev <= r_arm[1] & r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_ferr_wait <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_baud      <= w_baud_nx;
            r_bit       <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_ferr_wait <= w_ferr_wait_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_baud_nx      = r_baud + 1'b1;
        w_bit_nx       = r_bit;
        w_shift_nx     = r_shift;
        w_ferr_wait_nx = r_ferr_wait;
        w_push         = 1'b0;
        w_ferr_set     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nx      = '0;
                w_bit_nx       = '0;
                w_ferr_wait_nx = 1'b0;
                if (r_rx_prev && !r_rx_s) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_baud == L_HALF_END) begin
                    w_baud_nx  = '0;
                    w_state_nx = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud == L_BIT_END) begin
                    w_baud_nx  = '0;
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_ferr_wait) begin
                    w_baud_nx = '0;
                    if (r_rx_s) begin
                        w_ferr_wait_nx = 1'b0;
                        w_state_nx     = S_IDLE;
                    end
                end else if (r_baud == L_BIT_END) begin
                    w_baud_nx = '0;
                    if (r_rx_s) begin
                        w_push     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr_set     = 1'b1;
                        w_ferr_wait_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == 5'd0);
    assign w_pop   = rd_en & ~w_empty;
    assign w_wr    = ~reset & w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_valid   = ~w_empty;
    assign rx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=16, FIFO_DEPTH=8.
// Each comparison is an immediate assertion against a hand-derived value.
module tb_uart_rx_fifo;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       rd_en   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit plus 8 data bits; leaves the stop level on the line.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(16);
        end
        rx = stop;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1);
        tick(16);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        chk(tag, rx_data, exp);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        tick(3);

        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("empty_rd_count", fifo_count, 0);
        chk("empty_rd_valid", rx_valid, 0);

        // 0xA5: stop sample is 155 cycles after the start edge is driven
        send_frame(8'hA5, 1'b1);
        tick(10);
        chk("a5_pre_valid", rx_valid, 0);
        tick(1);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_count", fifo_count, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_ovr", overrun, 0);
        tick(5);
        pop("a5_pop", 8'hA5);
        chk("a5_after_valid", rx_valid, 0);
        chk("a5_after_data", rx_data, 8'h00);

        send_frame(8'h3C, 1'b0);
        tick(16);
        rx = 1'b1;
        tick(4);
        chk("fe_flag", frame_err, 1);
        chk("fe_count", fifo_count, 0);
        tick(20);
        send_byte(8'h11);
        chk("fe_next_data", rx_data, 8'h11);
        chk("fe_next_count", fifo_count, 1);
        chk("fe_sticky", frame_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("fe_clr", frame_err, 0);
        pop("fe_pop", 8'h11);
        chk("fe_empty", fifo_count, 0);

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_ovr", overrun, 0);

        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i));
        end
        chk("ovr_count", fifo_count, 8);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ferr", frame_err, 0);
        for (int i = 1; i <= 8; i++) begin
            pop("ovr_read", 8'(i));
        end
        chk("ovr_drain_count", fifo_count, 0);
        chk("ovr_drain_valid", rx_valid, 0);
        chk("ovr_sticky", overrun, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h0A + i));
        end
        chk("wrap_count", fifo_count, 3);
        for (int i = 0; i < 3; i++) begin
            pop("wrap_read", 8'(8'h0A + i));
        end
        chk("wrap_empty", fifo_count, 0);

        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h20 + i));
        end
        chk("full_count", fifo_count, 8);
        send_frame(8'h55, 1'b1);
        tick(10);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("fullpop_count", fifo_count, 8);
        chk("fullpop_ovr", overrun, 0);
        chk("fullpop_head", rx_data, 8'h21);
        tick(5);
        for (int i = 1; i < 8; i++) begin
            pop("fullpop_read", 8'(8'h20 + i));
        end
        pop("fullpop_last", 8'h55);
        chk("fullpop_empty", fifo_count, 0);
        chk("fullpop_valid", rx_valid, 0);

        send_byte(8'h77);
        chk("mid_pre_count", fifo_count, 1);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(16);
        end
        rx = 1'b0;
        tick(4);
        reset   = 1'b1;
        rd_en   = 1'b1;
        err_clr = 1'b1;
        tick(1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_data", rx_data, 8'h00);
        tick(1);
        reset   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        tick(40);
        chk("mid_low_count", fifo_count, 0);
        rx = 1'b1;
        tick(200);
        chk("mid_idle_count", fifo_count, 0);
        chk("mid_idle_valid", rx_valid, 0);
        chk("mid_idle_ferr", frame_err, 0);
        send_byte(8'h42);
        chk("mid_next_data", rx_data, 8'h42);
        chk("mid_next_count", fifo_count, 1);
        chk("mid_next_ferr", frame_err, 0);
        chk("mid_next_ovr", overrun, 0);
        pop("mid_next_pop", 8'h42);
        chk("mid_final_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
